select_decoder_5_32: RTL and testbench
======================================

# select_decoder_5_32

Registered 5-to-32 one-hot select decoder with a small request queue. It is the inverse of the datapath's 32-to-5 bus-select encoder. It accepts 5-bit select codes over a valid/ready handshake and drives exactly one of 32 enable lines per accepted legal code, for one cycle (or a stretched window). It sits between the control unit and the register-file/bus-source enables, so that several queued select requests issue back-to-back without combinational glitching.

## Interface
- `DEPTH`, default 2: request FIFO depth in entries (2..8).
- `HOLD`, default 1: enable-pulse width in cycles (1..15). Used only when `SEL_DEC_STRETCH_EN` is defined.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_code` in 5: select code. 0..23 are legal, 31 is a no-op, 24..30 are illegal.
- `req_ready` out 1: queue can accept a request this cycle.
- `dec_out` out 32: registered one-hot enable.
- `dec_valid` out 1: high whenever `dec_out` is non-zero.
- `busy` out 1: queue non-empty or pulse in progress.
- `err_pulse` out 1: one-cycle flag, high when an illegal code is popped.
- `err_seen` out 1: sticky illegal-code flag.
- `err_code` out 5: last illegal code popped.

## Operation
- Accept on `req_valid & req_ready`. `req_ready = !full & !reset`. A request offered while `req_ready` is low is not accepted and must be held by the source.
- FIFO: `DEPTH` entries of 5 bits, in-order. There is no pass-through: a full queue deasserts `req_ready` even if a pop occurs the same cycle. A push and a pop in the same cycle on a non-full, non-empty queue leaves the occupancy unchanged.
- Output stage has two states: IDLE and PULSE.
  - IDLE, queue non-empty: pop the head.
    - Legal code n: `dec_out <= 1<<n`, `dec_valid <= 1`. Go to PULSE if the pulse width is greater than 1; otherwise stay IDLE and remain eligible to pop again next cycle.
    - Code 31: consumed in one cycle. `dec_out` and `dec_valid` go low, no error.
    - Codes 24..30: consumed in one cycle. `dec_out` goes to 0, `err_pulse <= 1`, `err_seen <= 1`, `err_code <= code`.
  - PULSE: hold `dec_out` and decrement the hold counter. When the count reaches 0, clear `dec_out` and `dec_valid` and return to IDLE. No pop occurs during PULSE except in the final pulse cycle, where the next legal code may load directly so that pulses are back-to-back.
- `dec_out` is never multi-hot. `popcount(dec_out)` is always 0 or 1.
- Reset values: `dec_out` = 0, `dec_valid` = 0, `busy` = 0, `err_pulse` = 0, `err_seen` = 0, `err_code` = 0, FIFO empty, state IDLE, `req_ready` = 0 while `reset` is high and 1 on the first cycle after.
- Reset mid-pulse or with the queue non-empty: all queued codes are discarded and outputs take their reset values at the next edge.

## Timing
- Latency: a code accepted at edge k into an empty queue with IDLE output appears on `dec_out` after edge k+1.
- Throughput: one code per cycle when the pulse width is 1. With width W, one legal code per W cycles. No-op and illegal codes always cost exactly one cycle.
- `err_pulse` is high for exactly the one cycle in which the illegal code occupies the output slot.
- `busy` is combinational from FIFO count and state. It falls in the same cycle the last pulse cycle completes with the queue empty.

## Configuration
- `SEL_DEC_STRETCH_EN` defined: pulse width = `HOLD`. The 4-bit hold counter and the PULSE state are built.
- `SEL_DEC_STRETCH_EN` undefined: pulse width is fixed at 1, `HOLD` is ignored, and the PULSE state and counter are absent.

## Structure
- Package `sel_dec_pkg` holds:
  - `CODE_W`=5, `OUT_W`=32, `MAX_LEGAL`=23, `NOP_CODE`=31.
  - The state enum `{IDLE, PULSE}`.
  - Function `onehot(code)`.
- One sub-module, `sel_dec_fifo`: parameterized synchronous FIFO with `push`, `pop`, `full`, `empty`, `count` and synchronous active-high `reset`.

## Test plan
- Reset, then push code 5 alone: `dec_out` = 32'h00000020 one cycle after acceptance, for 1 cycle; `busy` returns to 0.
- Push 0, 23, 31, 7 back-to-back (width 1): outputs 32'h1, 32'h00800000, 0, 32'h80 on consecutive cycles; no error.
- Push 24 then 3: `err_pulse` high for 1 cycle, `err_seen` = 1, `err_code` = 24; next cycle `dec_out` = 32'h8.
- Hold `dec_out` stalled (DEPTH=2, stretch with HOLD=4) while pushing 3 codes: third push sees `req_ready` = 0 until a pop. Each legal code is held exactly 4 cycles, back-to-back, never multi-hot.
- Assert `reset` in the 2nd cycle of a 4-cycle pulse with 2 codes queued: next edge gives `dec_out` = 0, `busy` = 0, `err_seen` = 0. Queued codes never appear.
- Random valid/ready stress: checker confirms in-order issue and popcount ≤ 1 at all times.

Source files
------------

// File: rtl/sel_dec_pkg.sv
// Shared constants, output-stage state type and the one-hot helper for the
// 5-to-32 select decoder.
package sel_dec_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned OUT_W  = 32;

    localparam logic [CODE_W-1:0] MAX_LEGAL = 5'd23;
    localparam logic [CODE_W-1:0] NOP_CODE  = 5'd31;

    typedef enum logic [0:0] {
        IDLE,
        PULSE
    } sel_dec_state_e;

    function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sel_dec_fifo.sv
// Small in-order synchronous FIFO with occupancy count; pushes when full and
// pops when empty are ignored.
module sel_dec_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 5,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/select_decoder_5_32.sv
// Registered 5-to-32 one-hot select decoder fed by a request queue.
// Define SEL_DEC_STRETCH_EN to stretch each enable to HOLD cycles.
module select_decoder_5_32
    import sel_dec_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned HOLD  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [CODE_W-1:0] req_code,
    output logic              req_ready,
    output logic [OUT_W-1:0]  dec_out,
    output logic              dec_valid,
    output logic              busy,
    output logic              err_pulse,
    output logic              err_seen,
    output logic [CODE_W-1:0] err_code
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || DEPTH > 8 || HOLD == 0 || HOLD > 15) begin : g_bad_param
        $error("select_decoder_5_32: DEPTH must be 2..8 and HOLD 1..15");
    end

    logic [CODE_W-1:0] head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              hold_active;

    logic [OUT_W-1:0]  dec_out_q, dec_out_d;
    logic              dec_valid_q, dec_valid_d;
    logic              err_pulse_q, err_pulse_d;
    logic              err_seen_q, err_seen_d;
    logic [CODE_W-1:0] err_code_q, err_code_d;

    // No pass-through: readiness depends only on the registered occupancy.
    assign req_ready = ~full & ~reset;
    assign push      = req_valid & req_ready;

    sel_dec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (req_code),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        pop         = 1'b0;
        dec_out_d   = dec_out_q;
        dec_valid_d = dec_valid_q;
        err_pulse_d = 1'b0;
        err_seen_d  = err_seen_q;
        err_code_d  = err_code_q;
        if (!hold_active) begin
            if (!empty) begin
                pop = 1'b1;
                if (head <= MAX_LEGAL) begin
                    dec_out_d   = onehot(head);
                    dec_valid_d = 1'b1;
                end else begin
                    dec_out_d   = '0;
                    dec_valid_d = 1'b0;
                    if (head != NOP_CODE) begin
                        err_pulse_d = 1'b1;
                        err_seen_d  = 1'b1;
                        err_code_d  = head;
                    end
                end
            end else begin
                dec_out_d   = '0;
                dec_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_out_q   <= '0;
            dec_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_seen_q  <= 1'b0;
            err_code_q  <= '0;
        end else begin
            dec_out_q   <= dec_out_d;
            dec_valid_q <= dec_valid_d;
            err_pulse_q <= err_pulse_d;
            err_seen_q  <= err_seen_d;
            err_code_q  <= err_code_d;
        end
    end

`ifdef SEL_DEC_STRETCH_EN
    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    sel_dec_state_e state_q, state_d;
    logic [3:0]     hold_cnt_q, hold_cnt_d;
    logic           load_pulse;

    // A zero count marks the final pulse cycle, where the next code may pop.
    assign hold_active = (state_q == PULSE) && (hold_cnt_q != 4'd0);
    assign load_pulse  = pop && (head <= MAX_LEGAL);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (hold_active) begin
            hold_cnt_d = hold_cnt_q - 4'd1;
        end else if (load_pulse && HOLD > 1) begin
            state_d    = PULSE;
            hold_cnt_d = HOLD_M1;
        end else begin
            state_d    = IDLE;
            hold_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign busy = (count != '0) || (state_q == PULSE);
`else
    assign hold_active = 1'b0;
    assign busy        = (count != '0);
`endif

    assign dec_out   = dec_out_q;
    assign dec_valid = dec_valid_q;
    assign err_pulse = err_pulse_q;
    assign err_seen  = err_seen_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_select_decoder_5_32.sv
// Self-checking bench for select_decoder_5_32: directed cases plus randomized
// traffic checked against a queue-based reference model.
module tb_select_decoder_5_32;

    localparam int unsigned DEPTH = 2;
`ifdef SEL_DEC_STRETCH_EN
    localparam int unsigned HOLD = 4;
`else
    localparam int unsigned HOLD = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [4:0]  req_code;
    logic        req_ready;
    logic [31:0] dec_out;
    logic        dec_valid;
    logic        busy;
    logic        err_pulse;
    logic        err_seen;
    logic [4:0]  err_code;

    always #5 clk = ~clk;

    select_decoder_5_32 #(
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .dec_out   (dec_out),
        .dec_valid (dec_valid),
        .busy      (busy),
        .err_pulse (err_pulse),
        .err_seen  (err_seen),
        .err_code  (err_code)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: pending codes plus how many cycles the visible enable
    // still has to stay up (counting the current one).
    int          q[$];
    logic [31:0] m_out;
    int          m_left;
    bit          m_errp;
    bit          m_errs;
    logic [4:0]  m_errc;
    bit          m_accept;
    int          hold_len[32];

    task automatic model_step();
        m_accept = 1'b0;
        if (reset) begin
            q.delete();
            m_out  = '0;
            m_left = 0;
            m_errp = 1'b0;
            m_errs = 1'b0;
            m_errc = '0;
        end else begin
            bit acc = req_valid && (q.size() < DEPTH);
            m_errp = 1'b0;
            if (q.size() != 0 && m_left <= 1) begin
                int c = q.pop_front();
                if (c <= 23) begin
                    m_out  = 32'd1 << c;
                    m_left = HOLD;
                end else begin
                    m_out  = '0;
                    m_left = 0;
                    if (c != 31) begin
                        m_errp = 1'b1;
                        m_errs = 1'b1;
                        m_errc = 5'(c);
                    end
                end
            end else if (m_left > 1) begin
                m_left--;
            end else begin
                m_out  = '0;
                m_left = 0;
            end
            if (acc) q.push_back(int'(req_code));
            m_accept = acc;
        end
    endtask

    task automatic compare_all();
        check("dec_out", dec_out, m_out);
        check("dec_valid", dec_valid, m_out != 0);
        check("busy", busy, (q.size() != 0) || (HOLD > 1 && m_left > 0));
        check("err_pulse", err_pulse, m_errp);
        check("err_seen", err_seen, m_errs);
        check("err_code", err_code, m_errc);
        check("req_ready", req_ready, !reset && (q.size() < DEPTH));
        check("onehot", $countones(dec_out) <= 1, 1);
        for (int b = 0; b < 32; b++) if (dec_out[b]) hold_len[b]++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [4:0] c);
        req_valid = v;
        req_code  = c;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0);
        cycle();
        cycle();
        check("rst_dec_out", dec_out, 32'h0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", req_ready, 1);
        cycle();

`ifndef SEL_DEC_STRETCH_EN
        // Single code: visible one cycle after acceptance, for one cycle.
        drive(1, 5);  cycle();
        drive(0, 0);  cycle();
        check("t1_out", dec_out, 32'h0000_0020);
        check("t1_valid", dec_valid, 1);
        cycle();
        check("t1_clear", dec_out, 32'h0);
        check("t1_busy", busy, 0);

        // Back-to-back issue including a no-op.
        drive(1, 0);  cycle();
        drive(1, 23); cycle();
        check("t2_out0", dec_out, 32'h0000_0001);
        drive(1, 31); cycle();
        check("t2_out23", dec_out, 32'h0080_0000);
        drive(1, 7);  cycle();
        check("t2_nop", dec_out, 32'h0);
        drive(0, 0);  cycle();
        check("t2_out7", dec_out, 32'h0000_0080);
        check("t2_noerr", err_seen, 0);
        cycle();

        // Illegal code followed by a legal one.
        drive(1, 24); cycle();
        drive(1, 3);  cycle();
        check("t3_errp", err_pulse, 1);
        check("t3_errs", err_seen, 1);
        check("t3_errc", err_code, 24);
        check("t3_out0", dec_out, 32'h0);
        drive(0, 0);  cycle();
        check("t3_out3", dec_out, 32'h0000_0008);
        check("t3_errp_low", err_pulse, 0);
        cycle();
`else
        // Three codes into a 2-deep queue with 4-cycle pulses.
        foreach (hold_len[b]) hold_len[b] = 0;
        drive(1, 1); cycle();
        drive(1, 2); cycle();
        drive(1, 3); cycle();
        check("t4_full_ready", req_ready, 0);
        for (int g = 0; g < 20 && !m_accept; g++) cycle();
        drive(0, 0);
        for (int g = 0; g < 16; g++) cycle();
        check("t4_len1", hold_len[1], 4);
        check("t4_len2", hold_len[2], 4);
        check("t4_len3", hold_len[3], 4);
        check("t4_idle", busy, 0);

        // Reset in the second cycle of a pulse with two codes queued.
        drive(1, 25); cycle();
        drive(1, 5);  cycle();
        drive(1, 6);  cycle();
        drive(1, 7);  cycle();
        check("t5_pre_errs", err_seen, 1);
        check("t5_pre_out", dec_out, 32'h0000_0020);
        reset = 1'b1;
        drive(0, 0);
        cycle();
        check("t5_out", dec_out, 32'h0);
        check("t5_busy", busy, 0);
        check("t5_errs", err_seen, 0);
        reset = 1'b0;
        foreach (hold_len[b]) hold_len[b] = 0;
        for (int g = 0; g < 8; g++) cycle();
        check("t5_no6", hold_len[6], 0);
        check("t5_no7", hold_len[7], 0);
`endif

        // Random traffic; a refused offer is held until accepted.
        drive(0, 0);
        for (int i = 0; i < 3000; i++) begin
            if (!(req_valid && !m_accept)) begin
                int r = $urandom_range(15);
                req_valid = ($urandom_range(3) != 0);
                if (r < 11)      req_code = 5'($urandom_range(23));
                else if (r < 13) req_code = 5'd31;
                else             req_code = 5'($urandom_range(30, 24));
            end
            reset = ($urandom_range(199) == 0);
            cycle();
        end
        reset = 1'b0;
        drive(0, 0);
        for (int g = 0; g < 20; g++) cycle();
        check("final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
